// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ local requesters share one AXI4-Lite slave,
// running one single-beat read or write at a time and routing the response back to the winner.
module axi_lite_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*ADDRESS-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic [1:0]                         rsp_resp,
  output logic                               busy,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic [ADDRESS-1:0]                 M_AWADDR,
  output logic                               M_AWVALID,
  input  logic                               M_AWREADY,
  output logic [DATA_WIDTH-1:0]              M_WDATA,
  output logic [DATA_WIDTH/8-1:0]            M_WSTRB,
  output logic                               M_WVALID,
  input  logic                               M_WREADY,
  input  logic [1:0]                         M_BRESP,
  input  logic                               M_BVALID,
  output logic                               M_BREADY,
  output logic [ADDRESS-1:0]                 M_ARADDR,
  output logic                               M_ARVALID,
  input  logic                               M_ARREADY,
  input  logic [DATA_WIDTH-1:0]              M_RDATA,
  input  logic [1:0]                         M_RRESP,
  input  logic                               M_RVALID,
  output logic                               M_RREADY
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [ADDRESS-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  logic [ADDRESS-1:0]      addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]       wstrb_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDRESS +: ADDRESS];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[g] = req_wstrb[g*STRB_W +: STRB_W];
  end

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;

  // Search starts at rr_ptr_q so the last winner drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    req_ready  = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          grant_id_d        = win_id;
          addr_d            = addr_arr[win_id];
          wdata_d           = wdata_arr[win_id];
          wstrb_d           = wstrb_arr[win_id];
          aw_done_d         = 1'b0;
          w_done_d          = 1'b0;
          rr_ptr_d          = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_W'(1);
          state_d           = req_write[win_id] ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // AW and W retire independently; each VALID drops once its own handshake is seen.
        aw_done_d = aw_done_q | (M_AWVALID & M_AWREADY);
        w_done_d  = w_done_q | (M_WVALID & M_WREADY);
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (M_BVALID) begin
          resp_d  = M_BRESP;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RADDR: begin
        if (M_ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (M_RVALID) begin
          resp_d  = M_RRESP;
          rdata_d = M_RDATA;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == S_RSP) && (grant_id_q == ID_W'(i));
    end
  end

  assign rsp_rdata = (state_q == S_RSP) ? rdata_q : '0;
  assign rsp_resp  = (state_q == S_RSP) ? resp_q : 2'b00;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_id_q;

  assign M_AWADDR  = addr_q;
  assign M_ARADDR  = addr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_AWVALID = (state_q == S_WADDR) && !aw_done_q;
  assign M_WVALID  = (state_q == S_WADDR) && !w_done_q;
  assign M_BREADY  = (state_q == S_WRESP);
  assign M_ARVALID = (state_q == S_RADDR);
  assign M_RREADY  = (state_q == S_RDATA);

endmodule
